ecc_enc_dec: RTL and testbench
==============================

Name: ecc_enc_dec

Overview:
Extended-Hamming (SECDED) encode/decode engine directly downstream of the APB register bank. It consumes the bank's CTRL, DATA_IN, CODEWORD_WIDTH and NOISE registers plus its start strobe. It executes one operation per start: encode, decode, or full channel (encode, inject noise, decode). It returns DATA_OUT, num_of_errors and a one-cycle operation_done.

Parameters:
AMBA_WORD, 32, width of every register input from the APB bank.
DATA_WIDTH, 32, width of DATA_OUT; must be >= 32.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  operation request; sampled only in IDLE
CTRL  in  AMBA_WORD  [1:0] selects the operation: 0 = encode, 1 = decode, 2 = full channel, 3 = illegal
DATA_IN  in  AMBA_WORD  encode: data in the low bits; decode: codeword in the low bits
CODEWORD_WIDTH  in  AMBA_WORD  [1:0] selects codeword length n: 0 = 8, 1 = 16, 2 = 32, 3 = treated as 32
NOISE  in  AMBA_WORD  error pattern XORed into the codeword in full-channel mode
DATA_OUT  out  DATA_WIDTH  result, zero-extended
operation_done  out  1  one-cycle completion pulse
num_of_errors  out  2  0 = none, 1 = corrected, 2 = double error detected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst = 0, asynchronous): FSM goes to IDLE; DATA_OUT = 0, num_of_errors = 0, operation_done = 0, busy = 0; all working registers cleared. Reset mid-operation aborts the operation with no done pulse.
- Code layout for codeword length n:
  - Codeword bit i (i < n-1) holds Hamming position i+1.
  - Parity bits sit at positions 1, 2, 4, 8, 16 (those below n).
  - Data bits fill the remaining positions in ascending order, starting from data LSB.
  - Bit n-1 is overall parity, making the total even.
  - Data length k = 4 / 11 / 26 for n = 8 / 16 / 32.
- IDLE, start = 1: latch CTRL[1:0], the width code, DATA_IN and NOISE into working registers. Input changes after this edge have no effect. Next state by op: ENC for 0 and 2, SYN for 1, DONE for 3. A latched decode codeword keeps only its low n bits.
- ENC: codeword from the low k data bits written to cw. Op 0 loads DATA_OUT = cw and num_of_errors = 0, then goes to DONE. Op 2 goes to NOISE.
- NOISE: cw <= cw ^ (NOISE masked to n bits), then SYN.
- SYN: register the syndrome (XOR of the positions of all set bits over positions 1..n-1) and the overall parity (XOR of all n bits), then CORR.
- CORR, error classification:
  - syndrome 0, parity 0: 0 errors.
  - parity 1: 1 error. Flip position = syndrome; syndrome 0 means bit n-1, so data is unaffected.
  - syndrome != 0, parity 0: 2 errors, no correction.
- CORR output: DATA_OUT = extracted k data bits (corrected when 1 error), zero-extended; num_of_errors set per the classification; then DONE.
- Illegal op (3): DATA_OUT = 0 and num_of_errors = 0, loaded in the transition into DONE.
- DONE: operation_done = 1 for exactly one cycle, then IDLE.
- Latency, counted from the edge that samples start to the cycle operation_done is high: encode 2, decode 3, full channel 5, illegal 1.
- start while busy (including DONE) is ignored; it is not queued.
- DATA_OUT and num_of_errors hold their values until the next completion.

Test Plan:
- Encode: CTRL = 0, width = 0, DATA_IN = 0xB, start -> 2 cycles later done = 1 for one cycle, DATA_OUT = 0x55, num_of_errors = 0.
- Decode with one error: CTRL = 1, width = 0, DATA_IN = 0x45 -> after 3 cycles DATA_OUT = 0xB, num_of_errors = 1. Repeat with DATA_IN = 0x55 -> 0xB, 0 errors. Repeat with DATA_IN = 0xD5 (parity bit flipped) -> 0xB, 1 error.
- Double error: CTRL = 1, width = 0, DATA_IN = 0x56 -> num_of_errors = 2, DATA_OUT = 0xB (uncorrected extraction).
- Full channel: CTRL = 2, width = 0, DATA_IN = 0xB, NOISE = 0x10 -> after 5 cycles DATA_OUT = 0xB, num_of_errors = 1. Repeat with NOISE = 0x0 -> 0 errors.
- Widths 16/32: random data with every single-bit NOISE pattern returns the original data with 1 error; every two-bit pattern returns 2 errors. Width code 3 behaves identically to 2.
- Control corner cases:
  - start pulses while busy -> ignored; exactly one done.
  - rst low mid-full-channel -> outputs 0 immediately, no done; a new op after release is correct.
  - CTRL = 3 -> done after 1 cycle, DATA_OUT = 0.

Source files
------------

// File: rtl/ecc_enc_dec.sv
// SECDED (extended Hamming) encode / decode / full-channel engine fed by the APB register bank.
// One operation per start strobe; codeword length 8, 16 or 32 with overall parity in the top bit.
module ecc_enc_dec #(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AMBA_WORD-1:0]  CTRL,
  input  logic [AMBA_WORD-1:0]  DATA_IN,
  input  logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0]  NOISE,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  operation_done,
  output logic [1:0]            num_of_errors,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC,
    S_NOISE,
    S_SYN,
    S_CORR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]            r_op;
  logic [1:0]            r_wcode;
  logic [25:0]           r_data;
  logic [31:0]           r_noise;
  logic [31:0]           r_cw;
  logic [4:0]            r_syn;
  logic                  r_par;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [1:0]            r_nerr;

  logic [31:0] w_n_mask;
  logic [31:0] w_lo_mask;
  logic [25:0] w_k_mask;
  logic [4:0]  w_top;
  logic [31:0] w_h_enc;
  logic [31:0] w_cw_lo;
  logic [31:0] w_enc_cw;
  logic [31:0] w_flip;
  logic [31:0] w_cw_fix;
  logic [31:0] w_dec_data;
  logic [1:0]  w_nerr_dec;
  logic        w_unused;

  function automatic logic [31:0] f_n_mask(input logic [1:0] wcode);
    case (wcode)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Returns a vector indexed by Hamming position (bit 0 unused): data in
  // non-power-of-two slots, even parity in the power-of-two slots.
  function automatic logic [31:0] f_place(input logic [25:0] d);
    logic [31:0] h;
    logic        par;
    int          j;
    h = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        h[p] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int p = 1; p < 32; p++) begin
        if (p[b]) par = par ^ h[p];
      end
      h[1 << b] = par;
    end
    return h;
  endfunction

  function automatic logic [25:0] f_extract(input logic [31:0] h);
    logic [25:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = h[p];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [4:0] f_syndrome(input logic [31:0] cw_lo);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 31; i++) begin
      if (cw_lo[i]) s = s ^ 5'(i + 1);
    end
    return s;
  endfunction

  always_comb begin
    w_n_mask = f_n_mask(r_wcode);
    case (r_wcode)
      2'd0:    begin w_k_mask = 26'h000_000F; w_top = 5'd7;  end
      2'd1:    begin w_k_mask = 26'h000_07FF; w_top = 5'd15; end
      default: begin w_k_mask = 26'h3FF_FFFF; w_top = 5'd31; end
    endcase
  end

  assign w_lo_mask = w_n_mask >> 1;
  assign w_unused  = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

  // Encoder: shift position 1 down to bit 0, then append overall parity at bit n-1.
  assign w_h_enc  = f_place(r_data & w_k_mask);
  assign w_cw_lo  = (w_h_enc >> 1) & w_lo_mask;
  assign w_enc_cw = w_cw_lo | (32'(^w_cw_lo) << w_top);

  // A lone parity error with zero syndrome sits in bit n-1 and never touches data.
  assign w_flip     = (r_par && (r_syn != 5'd0)) ? (32'd1 << (r_syn - 5'd1)) : 32'd0;
  assign w_cw_fix   = r_cw ^ w_flip;
  assign w_dec_data = {6'b0, f_extract({w_cw_fix[30:0], 1'b0} & (w_lo_mask << 1)) & w_k_mask};
  assign w_nerr_dec = r_par ? 2'd1 : ((r_syn != 5'd0) ? 2'd2 : 2'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (CTRL[1:0])
            2'd0, 2'd2: w_state_next = S_ENC;
            2'd1:       w_state_next = S_SYN;
            default:    w_state_next = S_DONE;
          endcase
        end
      end
      S_ENC:   w_state_next = (r_op == 2'd2) ? S_NOISE : S_DONE;
      S_NOISE: w_state_next = S_SYN;
      S_SYN:   w_state_next = S_CORR;
      S_CORR:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= '0;
      r_wcode    <= '0;
      r_data     <= '0;
      r_noise    <= '0;
      r_cw       <= '0;
      r_syn      <= '0;
      r_par      <= 1'b0;
      r_data_out <= '0;
      r_nerr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= CTRL[1:0];
            r_wcode <= CODEWORD_WIDTH[1:0];
            r_data  <= DATA_IN[25:0];
            r_noise <= NOISE[31:0];
            r_cw    <= DATA_IN[31:0] & f_n_mask(CODEWORD_WIDTH[1:0]);
            if (CTRL[1:0] == 2'd3) begin
              r_data_out <= '0;
              r_nerr     <= 2'd0;
            end
          end
        end
        S_ENC: begin
          r_cw <= w_enc_cw;
          if (r_op != 2'd2) begin
            r_data_out <= DATA_WIDTH'(w_enc_cw);
            r_nerr     <= 2'd0;
          end
        end
        S_NOISE: r_cw <= r_cw ^ (r_noise & w_n_mask);
        S_SYN: begin
          r_syn <= f_syndrome(r_cw & w_lo_mask);
          r_par <= ^(r_cw & w_n_mask);
        end
        S_CORR: begin
          r_data_out <= DATA_WIDTH'(w_dec_data);
          r_nerr     <= w_nerr_dec;
        end
        default: ;
      endcase
    end
  end

  assign DATA_OUT       = r_data_out;
  assign num_of_errors  = r_nerr;
  assign operation_done = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_ecc_enc_dec.sv
// Directed + randomized bench for ecc_enc_dec against a position-level SECDED reference model.
module tb_ecc_enc_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] CTRL = '0;
  logic [31:0] DATA_IN = '0;
  logic [31:0] CODEWORD_WIDTH = '0;
  logic [31:0] NOISE = '0;
  logic [31:0] DATA_OUT;
  logic        operation_done;
  logic [1:0]  num_of_errors;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  ecc_enc_dec #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .CTRL           (CTRL),
    .DATA_IN        (DATA_IN),
    .CODEWORD_WIDTH (CODEWORD_WIDTH),
    .NOISE          (NOISE),
    .DATA_OUT       (DATA_OUT),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int n_of(input logic [1:0] wc);
    return (wc == 2'd0) ? 8 : (wc == 2'd1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] nmask_of(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] kmask_of(input int n);
    return (n == 8) ? 32'hF : (n == 16) ? 32'h7FF : 32'h3FF_FFFF;
  endfunction

  // Reference: bit pos-1 holds Hamming position pos; data fills non-power-of-two positions.
  function automatic logic [31:0] m_encode(input logic [31:0] data, input int n);
    logic [31:0] cw;
    logic        par;
    int          di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = data[di];
        di++;
      end
    end
    for (int p = 1; p < n; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < n; pos++)
        if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos-1];
      cw[p-1] = par;
    end
    cw[n-1] = ^cw;
    return cw;
  endfunction

  function automatic void m_decode(input logic [31:0] cw_in, input int n,
                                   output logic [31:0] d, output logic [1:0] e);
    logic [31:0] cw;
    int          syn;
    logic        par;
    int          di;
    cw  = cw_in & nmask_of(n);
    syn = 0;
    par = 1'b0;
    for (int pos = 1; pos <= n; pos++) begin
      if (cw[pos-1]) begin
        par = ~par;
        if (pos < n) syn = syn ^ pos;
      end
    end
    if (par) begin
      e = 2'd1;
      if (syn != 0) cw[syn-1] = ~cw[syn-1];
    end else begin
      e = (syn != 0) ? 2'd2 : 2'd0;
    end
    d  = '0;
    di = 0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[di] = cw[pos-1];
        di++;
      end
    end
  endfunction

  // Issues one op, scrambles the inputs right after start is sampled, waits (bounded) for done.
  task automatic run_op(input logic [1:0] op, input logic [1:0] wc, input logic [31:0] din,
                        input logic [31:0] nz, output logic [31:0] dout,
                        output logic [1:0] errs, output int lat);
    @(negedge clk);
    CTRL = {30'b0, op};
    CODEWORD_WIDTH = {30'b0, wc};
    DATA_IN = din;
    NOISE = nz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    CTRL = $urandom;
    CODEWORD_WIDTH = $urandom;
    DATA_IN = $urandom;
    NOISE = $urandom;
    lat = 1;
    while (!operation_done && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    dout = DATA_OUT;
    errs = num_of_errors;
    @(negedge clk);
    check("done_one_cycle", {31'b0, operation_done}, 32'd0);
  endtask

  task automatic exec(input string tag, input logic [1:0] op, input logic [1:0] wc,
                      input logic [31:0] din, input logic [31:0] nz, output logic [31:0] dout);
    logic [31:0] exp_d;
    logic [1:0]  exp_e;
    logic [1:0]  errs;
    int          lat;
    int          exp_lat;
    int          n;
    n = n_of(wc);
    case (op)
      2'd0: begin
        exp_d = m_encode(din & kmask_of(n), n);
        exp_e = 2'd0;
        exp_lat = 2;
      end
      2'd1: begin
        m_decode(din, n, exp_d, exp_e);
        exp_lat = 3;
      end
      2'd2: begin
        m_decode(m_encode(din & kmask_of(n), n) ^ nz, n, exp_d, exp_e);
        exp_lat = 5;
      end
      default: begin
        exp_d = '0;
        exp_e = 2'd0;
        exp_lat = 1;
      end
    endcase
    run_op(op, wc, din, nz, dout, errs, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, dout, exp_d);
    check({tag, "_errors"}, {30'b0, errs}, {30'b0, exp_e});
    $display("op=%0d wc=%0d din=0x%0h noise=0x%0h -> dout=0x%0h errs=%0d lat=%0d",
             op, wc, din, nz, dout, errs, lat);
  endtask

  logic [31:0] dout;
  logic [31:0] din;
  logic [31:0] busy_dout;
  logic [1:0]  busy_errs;
  int          done_cnt;
  int          n;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", DATA_OUT, 32'd0);
    check("rst_errors", {30'b0, num_of_errors}, 32'd0);
    check("rst_done", {31'b0, operation_done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;

    // Directed vectors
    exec("enc_0xB", 2'd0, 2'd0, 32'hB, 32'h0, dout);
    check("enc_0xB_literal", dout, 32'h55);
    exec("dec_0x45", 2'd1, 2'd0, 32'h45, 32'h0, dout);
    check("dec_0x45_literal", dout, 32'hB);
    exec("dec_0x55", 2'd1, 2'd0, 32'h55, 32'h0, dout);
    exec("dec_0xD5", 2'd1, 2'd0, 32'hD5, 32'h0, dout);
    exec("dec_0x56", 2'd1, 2'd0, 32'h56, 32'h0, dout);
    check("dec_0x56_literal", dout, 32'hB);
    exec("fc_noise10", 2'd2, 2'd0, 32'hB, 32'h10, dout);
    exec("fc_noise0", 2'd2, 2'd0, 32'hB, 32'h0, dout);
    repeat (3) @(negedge clk);
    check("hold_data_out", DATA_OUT, 32'hB);
    exec("illegal", 2'd3, 2'd0, 32'hFFFF_FFFF, 32'h0, dout);

    // Start pulses while busy (through DONE) must be ignored
    @(negedge clk);
    CTRL = 32'd2; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'hB; NOISE = 32'h10; start = 1'b1;
    done_cnt = 0;
    busy_dout = '0;
    busy_errs = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (operation_done) begin
        done_cnt++;
        busy_dout = DATA_OUT;
        busy_errs = num_of_errors;
      end
      if (c < 5) begin
        start = 1'b1;
        CTRL = $urandom; CODEWORD_WIDTH = $urandom; DATA_IN = $urandom; NOISE = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_done_count", done_cnt, 32'd1);
    check("busy_data", busy_dout, 32'hB);
    check("busy_errors", {30'b0, busy_errs}, 32'd1);
    $display("busy-ignore: done_count=%0d dout=0x%0h errs=%0d", done_cnt, busy_dout, busy_errs);

    // Reset mid full-channel
    @(negedge clk);
    CTRL = 32'd2; CODEWORD_WIDTH = 32'd1; DATA_IN = 32'h5A5; NOISE = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_data_out", DATA_OUT, 32'd0);
    check("midrst_errors", {30'b0, num_of_errors}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      if (operation_done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 32'd0);
    $display("mid-op reset: done_count=%0d", done_cnt);
    exec("post_rst_fc", 2'd2, 2'd1, 32'h5A5, 32'h400, dout);

    // Random encode / decode at all width codes
    for (int i = 0; i < 16; i++) begin
      exec("rnd_enc", 2'd0, 2'(i % 4), $urandom, 32'h0, dout);
      exec("rnd_dec", 2'd1, 2'(i % 4), $urandom, 32'h0, dout);
    end

    // Every single- and double-bit noise pattern at widths 16 and 32 (code 3 sampled)
    for (int wc = 1; wc < 4; wc++) begin
      n = n_of(2'(wc));
      for (int b = 0; b < n; b++) begin
        din = $urandom & kmask_of(n);
        exec("fc_single", 2'd2, 2'(wc), din, 32'd1 << b, dout);
        check("fc_single_orig", dout, din);
      end
      for (int b1 = 0; b1 < n; b1++) begin
        for (int b2 = b1 + 1; b2 < n; b2++) begin
          if (wc < 3 || $urandom_range(0, 24) == 0)
            exec("fc_double", 2'd2, 2'(wc), $urandom, (32'd1 << b1) | (32'd1 << b2), dout);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
